// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the AXI memory responder.
package axi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam int DEF_DATA_LENGTH  = 32;
    localparam int DEF_LINE_SIZE    = 64;
    localparam int DEF_MEM_BYTES    = 1048576;
    localparam int DEF_READ_LATENCY = 4;

    localparam int DEF_WORD_BYTES  = DEF_DATA_LENGTH / 8;
    localparam int DEF_BURST_WORDS = DEF_LINE_SIZE / DEF_WORD_BYTES;
    localparam int DEF_MEM_WORDS   = DEF_MEM_BYTES / DEF_WORD_BYTES;

    // Latency counter must be at least one bit wide even when READ_LATENCY is 0.
    function automatic int lat_bits(input int lat);
        int b;
        b = $clog2(lat + 1);
        return (b < 1) ? 1 : b;
    endfunction

    function automatic int word_lsb(input int data_length);
        return $clog2(data_length / 8);
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed backing store: synchronous write, asynchronous read.
module axi_mem_array #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_WORDS   = 262144,
    parameter int IDX_W       = $clog2(MEM_WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  logic [DATA_LENGTH-1:0] wdata,
    input  logic [IDX_W-1:0]       ridx,
    output logic [DATA_LENGTH-1:0] rdata
);

    logic [DATA_LENGTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axi_mem_responder.sv
// Simplified AXI3 memory slave: one full-line read or write burst at a time.
//
// state   | meaning
// IDLE    | waiting for AR (preferred) or AW
// RD_WAIT | counting down read latency
// RD_DATA | presenting read beats
// WR_DATA | accepting write beats
// WR_RESP | holding bvalid until bready
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int DATA_LENGTH  = DEF_DATA_LENGTH,
    parameter int LINE_SIZE    = DEF_LINE_SIZE,
    parameter int MEM_BYTES    = DEF_MEM_BYTES,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            axi_araddr,
    input  logic                   axi_arvalid,
    output logic                   axi_arready,
    output logic [DATA_LENGTH-1:0] axi_rdata,
    output logic                   axi_rvalid,
    input  logic                   axi_rready,
    input  logic [31:0]            axi_awaddr,
    input  logic                   axi_awvalid,
    output logic                   axi_awready,
    input  logic [DATA_LENGTH-1:0] axi_wdata,
    input  logic                   axi_wvalid,
    output logic                   axi_wready,
    output logic                   axi_bvalid,
    input  logic                   axi_bready
);

    localparam int WORD_BYTES  = DATA_LENGTH / 8;
    localparam int BURST_WORDS = LINE_SIZE / WORD_BYTES;
    localparam int MEM_WORDS   = MEM_BYTES / WORD_BYTES;
    localparam int ADDR_MSB    = $clog2(MEM_BYTES) - 1;
    localparam int WORD_LSB    = word_lsb(DATA_LENGTH);
    localparam int BEAT_W      = $clog2(BURST_WORDS);
    localparam int IDX_W       = $clog2(MEM_WORDS);
    localparam int LINE_W      = IDX_W - BEAT_W;
    localparam int LINE_LSB    = WORD_LSB + BEAT_W;
    localparam int LAT_W       = lat_bits(READ_LATENCY);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = '0;

    state_t                 state_q, state_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
    logic                   bvalid_q, bvalid_d;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_widx, mem_ridx;
    logic [DATA_LENGTH-1:0] mem_rdata;
    logic [LINE_W-1:0]      ar_line, aw_line;
    logic [BEAT_W-1:0]      beat_inc;

    // Address bits above the store size and below the line are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_araddr[31:ADDR_MSB+1], axi_araddr[LINE_LSB-1:0],
                                axi_awaddr[31:ADDR_MSB+1], axi_awaddr[LINE_LSB-1:0]};

    assign ar_line  = axi_araddr[ADDR_MSB:LINE_LSB];
    assign aw_line  = axi_awaddr[ADDR_MSB:LINE_LSB];
    assign beat_inc = beat_q + BEAT_W'(1);

    assign axi_arready = (state_q == IDLE) && !rst;
    assign axi_awready = (state_q == IDLE) && !axi_arvalid && !rst;
    assign axi_wready  = (state_q == WR_DATA) && !rst;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_bvalid  = bvalid_q;

    assign mem_widx = {line_q, beat_q};

    axi_mem_array #(
        .DATA_LENGTH (DATA_LENGTH),
        .MEM_WORDS   (MEM_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .widx  (mem_widx),
        .wdata (axi_wdata),
        .ridx  (mem_ridx),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        bvalid_d = bvalid_q;
        mem_we   = 1'b0;
        mem_ridx = {line_q, beat_inc};

        case (state_q)
            IDLE: begin
                mem_ridx = {ar_line, BEAT_ZERO};
                if (axi_arvalid && axi_arready) begin
                    line_d = ar_line;
                    beat_d = '0;
                    if (READ_LATENCY == 0) begin
                        state_d  = RD_DATA;
                        rvalid_d = 1'b1;
                        rdata_d  = mem_rdata;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                    end
                end else if (axi_awvalid && axi_awready) begin
                    line_d  = aw_line;
                    beat_d  = '0;
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                mem_ridx = {line_q, BEAT_ZERO};
                if (lat_q == '0) begin
                    state_d  = RD_DATA;
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_DATA: begin
                if (rvalid_q && axi_rready) begin
                    if (beat_q == LAST_BEAT) begin
                        rvalid_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_inc;
                        rdata_d = mem_rdata;
                    end
                end
            end
            WR_DATA: begin
                if (axi_wvalid && axi_wready) begin
                    mem_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                    end else begin
                        beat_d = beat_inc;
                    end
                end
            end
            WR_RESP: begin
                if (bvalid_q && axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            bvalid_q <= bvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: default build plus a zero-latency build.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    logic [31:0] z_araddr, z_awaddr, z_wdata, z_rdata;
    logic        z_arvalid, z_arready, z_rvalid, z_rready;
    logic        z_awvalid, z_awready, z_wvalid, z_wready, z_bvalid, z_bready;

    int passed = 0;
    int total  = 0;

    logic [31:0] rbuf [16];
    int          rlat;
    bit          rto, rgap, r_end_rvalid, r_end_arready;
    bit          bv_first, bv_held, bv_clear, wto;

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rvalid(rvalid), .axi_rready(rready),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bvalid(bvalid), .axi_bready(bready)
    );

    axi_mem_responder #(.READ_LATENCY(0), .MEM_BYTES(4096)) dut0 (
        .clk(clk), .rst(rst),
        .axi_araddr(z_araddr), .axi_arvalid(z_arvalid), .axi_arready(z_arready),
        .axi_rdata(z_rdata), .axi_rvalid(z_rvalid), .axi_rready(z_rready),
        .axi_awaddr(z_awaddr), .axi_awvalid(z_awvalid), .axi_awready(z_awready),
        .axi_wdata(z_wdata), .axi_wvalid(z_wvalid), .axi_wready(z_wready),
        .axi_bvalid(z_bvalid), .axi_bready(z_bready)
    );

    // Stimulus helpers only; every check lives in a test task. All start/end on a negedge.
    task automatic read_line(input logic [31:0] addr);
        int t;
        rto = 0; rgap = 0;
        araddr = addr; arvalid = 1; rready = 1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) rto = 1;
        @(negedge clk);
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        rlat = t + 1;
        for (int i = 0; i < 16; i++) begin
            if (!rvalid) rgap = 1;
            t = 0;
            while (!rvalid && t < 50) begin @(negedge clk); t++; end
            if (!rvalid) rto = 1;
            rbuf[i] = rdata;
            @(negedge clk);
        end
        r_end_rvalid  = rvalid;
        r_end_arready = arready;
    endtask

    task automatic w_beats(input logic [31:0] base, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            wdata = base + 32'(i); wvalid = 1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (!wready) wto = 1;
            @(negedge clk);
        end
        wvalid = 0;
    endtask

    task automatic finish_b(input int hold);
        bv_first = bvalid;
        bv_held  = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bvalid) bv_held = 0;
        end
        bready = 1;
        @(negedge clk);
        bv_clear = !bvalid;
    endtask

    task automatic write_line(input logic [31:0] addr, input logic [31:0] base, input int hold);
        int t;
        wto = 0;
        bready = (hold == 0);
        awaddr = addr; awvalid = 1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (!awready) wto = 1;
        @(negedge clk);
        awvalid = 0;
        w_beats(base, 16);
        finish_b(hold);
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        total++; if (arready !== 1'b0) $display("FAIL reset_arready got %b exp 0", arready); else passed++;
        total++; if (awready !== 1'b0) $display("FAIL reset_awready got %b exp 0", awready); else passed++;
        total++; if (wready !== 1'b0) $display("FAIL reset_wready got %b exp 0", wready); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", rvalid); else passed++;
        total++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid got %b exp 0", bvalid); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else passed++;
        total++; if (z_arready !== 1'b0) $display("FAIL reset_z_arready got %b exp 0", z_arready); else passed++;
        rst = 0;
        #1;
        total++; if (arready !== 1'b1) $display("FAIL post_reset_arready got %b exp 1", arready); else passed++;
        total++; if (awready !== 1'b1) $display("FAIL post_reset_awready got %b exp 1", awready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        write_line(32'h100, 32'hA000_0000, 0);
        total++; if (wto) $display("FAIL wr_handshake timeout got 1 exp 0"); else passed++;
        total++; if (!bv_first) $display("FAIL wr_bvalid_after_last got 0 exp 1"); else passed++;
        total++; if (!bv_clear) $display("FAIL wr_bvalid_clear got 1 exp 0"); else passed++;
        read_line(32'h100);
        total++; if (rto) $display("FAIL rd_timeout got 1 exp 0"); else passed++;
        total++; if (rlat !== 5) $display("FAIL rd_latency got %0d exp 5", rlat); else passed++;
        total++; if (rgap) $display("FAIL rd_consecutive got gap exp none"); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rbuf[i] !== 32'hA000_0000 + 32'(i))
                $display("FAIL rd_beat%0d got %h exp %h", i, rbuf[i], 32'hA000_0000 + 32'(i));
            else passed++;
        end
        total++; if (r_end_rvalid !== 1'b0) $display("FAIL rd_end_rvalid got %b exp 0", r_end_rvalid); else passed++;
        total++; if (r_end_arready !== 1'b1) $display("FAIL rd_end_arready got %b exp 1", r_end_arready); else passed++;
    endtask

    task automatic test_alias();
        read_line(32'h0010_010C);
        total++; if (rto) $display("FAIL alias_timeout got 1 exp 0"); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rbuf[i] !== 32'hA000_0000 + 32'(i))
                $display("FAIL alias_beat%0d got %h exp %h", i, rbuf[i], 32'hA000_0000 + 32'(i));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int t;
        araddr = 32'h100; arvalid = 1; rready = 1;
        @(negedge clk);
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) @(negedge clk);
        total++; if (rdata !== 32'hA000_0005) $display("FAIL bp_beat5 got %h exp a0000005", rdata); else passed++;
        rready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (rvalid !== 1'b1 || rdata !== 32'hA000_0005)
                $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=a0000005", k, rvalid, rdata);
            else passed++;
        end
        rready = 1;
        @(negedge clk);
        total++; if (rdata !== 32'hA000_0006) $display("FAIL bp_resume got %h exp a0000006", rdata); else passed++;
        t = 0;
        while (rvalid && t < 50) begin @(negedge clk); t++; end
        total++; if (rvalid !== 1'b0) $display("FAIL bp_drain got rvalid=%b exp 0", rvalid); else passed++;

        write_line(32'h300, 32'hB000_0000, 4);
        total++; if (!bv_first) $display("FAIL bbp_bvalid_set got 0 exp 1"); else passed++;
        total++; if (!bv_held) $display("FAIL bbp_bvalid_held got dropped exp held"); else passed++;
        total++; if (!bv_clear) $display("FAIL bbp_bvalid_clear got 1 exp 0"); else passed++;
    endtask

    task automatic test_collision();
        int t;
        araddr = 32'h100; awaddr = 32'h400; arvalid = 1; awvalid = 1; rready = 1;
        #1;
        total++; if (arready !== 1'b1) $display("FAIL col_arready got %b exp 1", arready); else passed++;
        total++; if (awready !== 1'b0) $display("FAIL col_awready got %b exp 0", awready); else passed++;
        @(negedge clk);
        arvalid = 0;
        total++; if (awready !== 1'b0) $display("FAIL col_awready_busy got %b exp 0", awready); else passed++;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        while (rvalid && t < 100) begin @(negedge clk); t++; end
        total++; if (awready !== 1'b1) $display("FAIL col_awready_idle got %b exp 1", awready); else passed++;
        @(negedge clk);
        awvalid = 0;
        total++; if (wready !== 1'b1) $display("FAIL col_wr_accepted got wready=%b exp 1", wready); else passed++;
        wto = 0; bready = 1;
        w_beats(32'hC000_0000, 16);
        finish_b(0);
        read_line(32'h400);
        total++; if (rbuf[0] !== 32'hC000_0000) $display("FAIL col_rd0 got %h exp c0000000", rbuf[0]); else passed++;
        total++; if (rbuf[15] !== 32'hC000_000F) $display("FAIL col_rd15 got %h exp c000000f", rbuf[15]); else passed++;
    endtask

    task automatic test_reset_mid_read();
        int t;
        araddr = 32'h100; arvalid = 1; rready = 1;
        @(negedge clk);
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 7; i++) @(negedge clk);
        total++; if (rdata !== 32'hA000_0007) $display("FAIL rst_rd_beat7 got %h exp a0000007", rdata); else passed++;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        rready = 0;
        total++; if (rvalid !== 1'b0) $display("FAIL rst_rd_rvalid got %b exp 0", rvalid); else passed++;
        total++; if (arready !== 1'b1) $display("FAIL rst_rd_arready got %b exp 1", arready); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rst_rd_rdata got %h exp 0", rdata); else passed++;
    endtask

    task automatic test_reset_mid_write();
        write_line(32'h200, 32'hD000_0000, 0);
        awaddr = 32'h200; awvalid = 1; wto = 0;
        @(negedge clk);
        awvalid = 0;
        w_beats(32'hE000_0000, 4);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        total++; if (wready !== 1'b0) $display("FAIL rst_wr_wready got %b exp 0", wready); else passed++;
        total++; if (arready !== 1'b1) $display("FAIL rst_wr_arready got %b exp 1", arready); else passed++;
        read_line(32'h200);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp;
            exp = (i < 4) ? 32'hE000_0000 + 32'(i) : 32'hD000_0000 + 32'(i);
            total++;
            if (rbuf[i] !== exp) $display("FAIL rst_wr_beat%0d got %h exp %h", i, rbuf[i], exp);
            else passed++;
        end
    endtask

    task automatic test_lat0();
        int t;
        z_awaddr = 32'h40; z_awvalid = 1; z_bready = 1;
        @(negedge clk);
        z_awvalid = 0;
        for (int i = 0; i < 16; i++) begin
            z_wdata = 32'hF000_0000 + 32'(i); z_wvalid = 1;
            @(negedge clk);
        end
        z_wvalid = 0;
        total++; if (z_bvalid !== 1'b1) $display("FAIL z_bvalid got %b exp 1", z_bvalid); else passed++;
        @(negedge clk);
        z_araddr = 32'h40; z_arvalid = 1; z_rready = 0;
        #1;
        total++; if (z_arready !== 1'b1) $display("FAIL z_arready got %b exp 1", z_arready); else passed++;
        @(negedge clk);
        z_arvalid = 0;
        total++; if (z_rvalid !== 1'b1) $display("FAIL z_rvalid_next got %b exp 1", z_rvalid); else passed++;
        total++; if (z_rdata !== 32'hF000_0000) $display("FAIL z_beat0 got %h exp f0000000", z_rdata); else passed++;
        z_rready = 1;
        @(negedge clk);
        total++; if (z_rdata !== 32'hF000_0001) $display("FAIL z_beat1 got %h exp f0000001", z_rdata); else passed++;
        t = 0;
        while (z_rvalid && t < 50) begin @(negedge clk); t++; end
        z_rready = 0;
    endtask

    initial begin
        araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
        wdata = '0; wvalid = 0; bready = 0;
        z_araddr = '0; z_arvalid = 0; z_rready = 0; z_awaddr = '0; z_awvalid = 0;
        z_wdata = '0; z_wvalid = 0; z_bready = 0;
        rst = 1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_alias();
        test_backpressure();
        test_collision();
        test_reset_mid_read();
        test_reset_mid_write();
        test_lat0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
